// File: rtl/sr_flag_arbiter.sv
// Round-robin arbiter applying set/reset/hold commands from NREQ requesters onto a shared SR flag bank.
// One command per two cycles, applied at the edge ending APPLY; losing requesters hold req until they see gnt.
module sr_flag_arbiter #(
    parameter int NREQ   = 4,
    parameter int NFLAGS = 8,
    parameter int IDXW   = 3
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NREQ-1:0]        req,
    input  logic [NREQ-1:0]        s,
    input  logic [NREQ-1:0]        r,
    input  logic [NREQ*IDXW-1:0]   idx,
    output logic [NREQ-1:0]        gnt,
    output logic [NFLAGS-1:0]      q,
    output logic                   busy,
    output logic                   illegal,
    output logic [7:0]             op_cnt
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic {
        IDLE  = 1'b0,
        APPLY = 1'b1
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic [PW-1:0]       r_ptr;
    logic [PW-1:0]       r_win;
    logic                r_s;
    logic                r_r;
    logic [IDXW-1:0]     r_idx;
    logic [NFLAGS-1:0]   r_q;
    logic [7:0]          r_op_cnt;

    logic [PW-1:0]       w_win;
    logic [PW-1:0]       w_cand;
    logic [NREQ-1:0]     w_gnt;
    logic                w_busy;
    logic                w_illegal;

    // Scan downwards so the last hit, i.e. the one closest to r_ptr, wins.
    always_comb begin
        w_win  = r_ptr;
        w_cand = r_ptr;
        for (int k = NREQ - 1; k >= 0; k--) begin
            w_cand = PW'((int'(r_ptr) + k) % NREQ);
            if (req[w_cand]) begin
                w_win = w_cand;
            end
        end
    end

    always_comb begin
        w_next    = r_state;
        w_gnt     = '0;
        w_busy    = 1'b0;
        w_illegal = 1'b0;
        case (r_state)
            IDLE: begin
                if (|req) begin
                    w_next = APPLY;
                end
            end
            APPLY: begin
                w_next       = IDLE;
                w_busy       = 1'b1;
                w_gnt[r_win] = 1'b1;
                w_illegal    = r_s & r_r;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= IDLE;
            r_ptr    <= '0;
            r_win    <= '0;
            r_s      <= 1'b0;
            r_r      <= 1'b0;
            r_idx    <= '0;
            r_q      <= '0;
            r_op_cnt <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == IDLE && |req) begin
                r_win <= w_win;
                r_s   <= s[w_win];
                r_r   <= r[w_win];
                r_idx <= idx[int'(w_win)*IDXW +: IDXW];
            end
            if (r_state == APPLY) begin
                r_op_cnt <= r_op_cnt + 8'd1;
                r_ptr    <= PW'((int'(r_win) + 1) % NREQ);
                // Out-of-range indices match no flag; s==r is a hold.
                for (int f = 0; f < NFLAGS; f++) begin
                    if (int'(r_idx) == f && (r_s ^ r_r)) begin
                        r_q[f] <= r_s;
                    end
                end
            end
        end
    end

    assign gnt     = w_gnt;
    assign busy    = w_busy;
    assign illegal = w_illegal;
    assign q       = r_q;
    assign op_cnt  = r_op_cnt;

endmodule
